pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB).
- Drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Inputs are ID-stage source info and the ID/EX and EX/MEM register outputs, plus the data-memory ready handshake.
- Handles RAW/load-use and status-register hazards, taken-branch flushes, multi-cycle memory freezes with a timeout, and saturating performance counters.

Parameters:
FWD_EN, 1, 1 = forwarding unit present (stall on load-use only); 0 = stall on any RAW match in EX or MEM
MEM_TIMEOUT, 255, consecutive FREEZE cycles before entering ERR (min 1)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
id_valid  in  1  ID holds a real instruction
id_src1  in  4  ID source register 1 (Rn)
id_src2  in  4  ID source register 2 (Rm/Rd for store)
id_two_src  in  1  id_src2 is a real read
id_uses_sr  in  1  ID instruction condition reads NZCV (cond != AL)
exe_wb_en  in  1  ID/EX wb_en
exe_mem_r_en  in  1  ID/EX mem_r_en
exe_s  in  1  ID/EX s (EX updates status register)
exe_b  in  1  ID/EX b (taken branch in EX)
exe_dest  in  4  ID/EX dest
mem_wb_en  in  1  EX/MEM wb_en
mem_dest  in  4  EX/MEM dest
mem_req  in  1  EX/MEM mem_r_en | mem_w_en
mem_ready  in  1  data memory completes access this cycle
perf_clr  in  1  synchronous clear of performance counters
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID flush
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX flush (bubble insert)
ex_mem_en  out  1  EX/MEM load enable
mem_wb_en_ctl  out  1  MEM/WB load enable
hazard  out  1  hazard stall is active this cycle
ctrl_state  out  2  0 = RUN, 1 = FREEZE, 2 = ERR
mem_timeout_err  out  1  sticky timeout error
stall_cnt  out  CNT_W  hazard bubble count
flush_cnt  out  CNT_W  branch flush count
freeze_cnt  out  CNT_W  memory freeze cycle count

Behaviour:
- Reset (rst = 0, asynchronous):
  - State RUN; wait_cnt = 0; all counters 0; mem_timeout_err = 0.
  - While reset is held, all enables and flushes are 0 and hazard = 0.
- Stage controls are combinational from state and inputs, so they act at the same clock edge. State, wait_cnt, error and counters are registered.
- RAW hazard terms:
  - ex_hit = exe_wb_en & (exe_dest == id_src1 | (id_two_src & exe_dest == id_src2)).
  - mem_hit is the same form using mem_wb_en and mem_dest.
  - R0 is a real register; there is no zero exclusion.
- hazard = id_valid & (raw | (id_uses_sr & exe_s)).
  - FWD_EN = 1: raw = ex_hit & exe_mem_r_en.
  - FWD_EN = 0: raw = ex_hit | mem_hit.
- Priority: ERR > freeze > branch > hazard > normal.
  - ERR or freeze (mem_req & !mem_ready): all five enables 0, flushes 0, hazard output forced 0.
  - Branch (exe_b): all enables 1, if_id_flush = 1, id_ex_flush = 1. The hazard is suppressed because the ID instruction is squashed.
  - Hazard: pc_en = 0, if_id_en = 0, id_ex_en = 1, id_ex_flush = 1, ex_mem_en = 1, mem_wb_en_ctl = 1.
  - Normal: all enables 1, flushes 0.
- FSM:
  - RUN -> FREEZE when mem_req & !mem_ready, with wait_cnt <= 1.
  - FREEZE, mem_ready = 1 -> RUN with wait_cnt <= 0. Controls stay frozen in this cycle because freeze is evaluated combinationally; the pipe advances on the next edge.
  - FREEZE, !mem_ready and wait_cnt == MEM_TIMEOUT -> ERR with mem_timeout_err <= 1.
  - FREEZE otherwise: wait_cnt increments.
  - ERR is absorbing until reset.
  - mem_req dropping during FREEZE (abnormal) -> RUN.
- Counters:
  - All counters saturate at 2^CNT_W - 1.
  - freeze_cnt increments each cycle freeze or ERR controls are driven.
  - flush_cnt increments once per cycle the branch controls are applied.
  - stall_cnt increments per hazard cycle.
  - perf_clr zeroes all three and wins over increments in the same cycle.
- Simultaneous events:
  - Branch + hazard: branch only.
  - Freeze + branch: freeze only; exe_b stays held, so the flush occurs after unfreeze.
- Reset mid-FREEZE returns to RUN immediately.

Decomposition:
- Shared package pipe_ctrl_pkg: state encodings RUN/FREEZE/ERR, CTRL_STATE_W = 2, REG_ADDR_W = 4.
- One sub-module: sat_counter (CNT_W, inc, clr, async active-low reset), instantiated three times.
- Hazard compare logic stays inline.

Test Plan:
- Load-use stall (FWD_EN = 1): exe_mem_r_en = 1, exe_wb_en = 1, exe_dest = 3, id_src1 = 3, id_valid = 1 -> pc_en = 0, if_id_en = 0, id_ex_flush = 1, hazard = 1; stall_cnt 0 -> 1. Same case with exe_mem_r_en = 0 -> no stall.
- FWD_EN = 0 MEM hit: mem_wb_en = 1, mem_dest = 5, id_two_src = 1, id_src2 = 5 -> hazard = 1. Same case with id_two_src = 0 -> hazard = 0.
- Branch overrides hazard: exe_b = 1 with a load-use match -> all enables 1, both flushes 1, hazard = 0, flush_cnt = 1, stall_cnt unchanged.
- Memory freeze: mem_req = 1, mem_ready = 0 for 4 cycles then 1 -> ctrl_state = 1 for 4 cycles, all enables 0 for 5 cycles, freeze_cnt = 5, back to RUN.
- Timeout: MEM_TIMEOUT = 3, mem_ready held 0 -> ERR after 3 FREEZE cycles, mem_timeout_err = 1, stays frozen; async rst = 0 -> RUN, error 0, counters 0.
- Saturation and clear: CNT_W = 2 with 5 hazard cycles -> stall_cnt = 3; perf_clr concurrent with a hazard -> stall_cnt = 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   ctrl_state_e : sequencer state encoding (RUN / FREEZE / ERR)
//   CTRL_STATE_W : width of the exported state code
//   REG_ADDR_W   : register-file address width (R0..R15)
package pipe_ctrl_pkg;

    localparam int CTRL_STATE_W = 2;
    localparam int REG_ADDR_W   = 4;

    typedef enum logic [CTRL_STATE_W-1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        ERR    = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   inc  : count one event this cycle
//   clr  : synchronous clear, wins over inc
//   cnt  : current count, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Stage enables/flushes are combinational from the registered sequencer state
// and the current hazard inputs; state, wait counter, sticky error and the
// performance counters are registered.
// Ports:
//   clk, rst (async, active-low)
//   ID source info     : id_valid, id_src1, id_src2, id_two_src, id_uses_sr
//   ID/EX outputs      : exe_wb_en, exe_mem_r_en, exe_s, exe_b, exe_dest
//   EX/MEM outputs     : mem_wb_en, mem_dest, mem_req
//   memory handshake   : mem_ready
//   perf_clr           : synchronous clear of the performance counters
//   stage controls     : pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
//                        ex_mem_en, mem_wb_en_ctl
//   status             : hazard, ctrl_state, mem_timeout_err
//   counters           : stall_cnt, flush_cnt, freeze_cnt
module pipeline_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter bit FWD_EN      = 1'b1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_ADDR_W-1:0]   id_src1,
    input  logic [REG_ADDR_W-1:0]   id_src2,
    input  logic                    id_two_src,
    input  logic                    id_uses_sr,
    input  logic                    exe_wb_en,
    input  logic                    exe_mem_r_en,
    input  logic                    exe_s,
    input  logic                    exe_b,
    input  logic [REG_ADDR_W-1:0]   exe_dest,
    input  logic                    mem_wb_en,
    input  logic [REG_ADDR_W-1:0]   mem_dest,
    input  logic                    mem_req,
    input  logic                    mem_ready,
    input  logic                    perf_clr,
    output logic                    pc_en,
    output logic                    if_id_en,
    output logic                    if_id_flush,
    output logic                    id_ex_en,
    output logic                    id_ex_flush,
    output logic                    ex_mem_en,
    output logic                    mem_wb_en_ctl,
    output logic                    hazard,
    output logic [CTRL_STATE_W-1:0] ctrl_state,
    output logic                    mem_timeout_err,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt,
    output logic [CNT_W-1:0]        freeze_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    logic ex_hit, mem_hit, raw, hazard_raw;
    logic freeze_act, err_act, branch_act;

    // R0 is a real register, so no zero-register exclusion here.
    assign ex_hit  = exe_wb_en & ((exe_dest == id_src1) | (id_two_src & (exe_dest == id_src2)));
    assign mem_hit = mem_wb_en & ((mem_dest == id_src1) | (id_two_src & (mem_dest == id_src2)));

    // With forwarding only a load in EX cannot be bypassed in time.
    assign raw        = FWD_EN ? (ex_hit & exe_mem_r_en) : (ex_hit | mem_hit);
    assign hazard_raw = id_valid & (raw | (id_uses_sr & exe_s));

    // FREEZE keeps the pipe held through the cycle mem_ready returns; the
    // pipe advances on the following edge.
    assign freeze_act = (state_q == FREEZE) | ((state_q == RUN) & mem_req & ~mem_ready);
    assign err_act    = (state_q == ERR);
    assign branch_act = rst & ~freeze_act & ~err_act & exe_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d = FREEZE;
                    wait_d  = WAIT_W'(1);
                end
            end
            FREEZE: begin
                if (!mem_req || mem_ready) begin
                    // Completion, or the request vanished: resume either way.
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ERR: begin
                // Absorbing until reset.
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en_ctl = 1'b0;
        hazard        = 1'b0;
        if (!rst || err_act || freeze_act) begin
            // Everything held; defaults already zero.
        end else if (exe_b) begin
            // ID instruction is squashed, so any hazard against it is moot.
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_en      = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_en     = 1'b1;
            mem_wb_en_ctl = 1'b1;
        end else if (hazard_raw) begin
            id_ex_en      = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_en     = 1'b1;
            mem_wb_en_ctl = 1'b1;
            hazard        = 1'b1;
        end else begin
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            id_ex_en      = 1'b1;
            ex_mem_en     = 1'b1;
            mem_wb_en_ctl = 1'b1;
        end
    end

    assign ctrl_state      = state_q;
    assign mem_timeout_err = err_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hazard),
        .clr (perf_clr),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (branch_act),
        .clr (perf_clr),
        .cnt (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk (clk),
        .rst (rst),
        .inc (freeze_act | err_act),
        .clr (perf_clr),
        .cnt (freeze_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller. Two instances share stimulus:
//   u_a : FWD_EN=1, MEM_TIMEOUT=255, CNT_W=16
//   u_b : FWD_EN=0, MEM_TIMEOUT=3,   CNT_W=2
// Control vector order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
//                        ex_mem_en, mem_wb_en_ctl, hazard}
module tb_pipeline_hazard_controller;

    localparam logic [7:0] C_NORM = 8'b1101_0110;
    localparam logic [7:0] C_HAZ  = 8'b0001_1111;
    localparam logic [7:0] C_BR   = 8'b1111_1110;
    localparam logic [7:0] C_HOLD = 8'b0000_0000;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_two_src, id_uses_sr;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       exe_wb_en, exe_mem_r_en, exe_s, exe_b;
    logic       mem_wb_en, mem_req, mem_ready, perf_clr;

    logic        pc_en_a, if_id_en_a, if_id_flush_a, id_ex_en_a, id_ex_flush_a;
    logic        ex_mem_en_a, mem_wb_en_ctl_a, hazard_a, err_a;
    logic [1:0]  state_a;
    logic [15:0] stall_a, flush_a, freeze_a;

    logic        pc_en_b, if_id_en_b, if_id_flush_b, id_ex_en_b, id_ex_flush_b;
    logic        ex_mem_en_b, mem_wb_en_ctl_b, hazard_b, err_b;
    logic [1:0]  state_b;
    logic [1:0]  stall_b, flush_b, freeze_b;

    logic [7:0] ctl_a, ctl_b;
    assign ctl_a = {pc_en_a, if_id_en_a, if_id_flush_a, id_ex_en_a, id_ex_flush_a,
                    ex_mem_en_a, mem_wb_en_ctl_a, hazard_a};
    assign ctl_b = {pc_en_b, if_id_en_b, if_id_flush_b, id_ex_en_b, id_ex_flush_b,
                    ex_mem_en_b, mem_wb_en_ctl_b, hazard_b};

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.FWD_EN(1'b1), .MEM_TIMEOUT(255), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_uses_sr(id_uses_sr),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_s(exe_s),
        .exe_b(exe_b), .exe_dest(exe_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_req(mem_req),
        .mem_ready(mem_ready), .perf_clr(perf_clr),
        .pc_en(pc_en_a), .if_id_en(if_id_en_a), .if_id_flush(if_id_flush_a),
        .id_ex_en(id_ex_en_a), .id_ex_flush(id_ex_flush_a), .ex_mem_en(ex_mem_en_a),
        .mem_wb_en_ctl(mem_wb_en_ctl_a), .hazard(hazard_a), .ctrl_state(state_a),
        .mem_timeout_err(err_a), .stall_cnt(stall_a), .flush_cnt(flush_a),
        .freeze_cnt(freeze_a)
    );

    pipeline_hazard_controller #(.FWD_EN(1'b0), .MEM_TIMEOUT(3), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_uses_sr(id_uses_sr),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_s(exe_s),
        .exe_b(exe_b), .exe_dest(exe_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_req(mem_req),
        .mem_ready(mem_ready), .perf_clr(perf_clr),
        .pc_en(pc_en_b), .if_id_en(if_id_en_b), .if_id_flush(if_id_flush_b),
        .id_ex_en(id_ex_en_b), .id_ex_flush(id_ex_flush_b), .ex_mem_en(ex_mem_en_b),
        .mem_wb_en_ctl(mem_wb_en_ctl_b), .hazard(hazard_b), .ctrl_state(state_b),
        .mem_timeout_err(err_b), .stall_cnt(stall_b), .flush_cnt(flush_b),
        .freeze_cnt(freeze_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic clr_in();
        id_valid = 1'b0; id_two_src = 1'b0; id_uses_sr = 1'b0;
        id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_s = 1'b0; exe_b = 1'b0;
        mem_wb_en = 1'b0; mem_req = 1'b0; mem_ready = 1'b1; perf_clr = 1'b0;
    endtask

    task automatic load_use();
        id_valid = 1'b1; id_src1 = 4'd3;
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3;
    endtask

    // One clock: through the rising edge, back to the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a branch pending: controls must still be zero.
        rst = 1'b0;
        clr_in();
        exe_b = 1'b1;
        @(negedge clk);
        #1;
        check("rst_ctl_a", 32'(ctl_a), 32'(C_HOLD));
        check("rst_ctl_b", 32'(ctl_b), 32'(C_HOLD));
        check("rst_state_a", 32'(state_a), 32'd0);
        check("rst_err_a", 32'(err_a), 32'd0);
        check("rst_stall_a", 32'(stall_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        clr_in();
        #1;
        check("idle_ctl_a", 32'(ctl_a), 32'(C_NORM));

        // Load-use: both configurations stall.
        load_use();
        #1;
        check("lu_ctl_a", 32'(ctl_a), 32'(C_HAZ));
        check("lu_ctl_b", 32'(ctl_b), 32'(C_HAZ));
        step();
        check("lu_stall_a", 32'(stall_a), 32'd1);
        check("lu_stall_b", 32'(stall_b), 32'd1);

        // ALU producer: forwarding covers it, no-forward config still stalls.
        exe_mem_r_en = 1'b0;
        #1;
        check("alu_ctl_a", 32'(ctl_a), 32'(C_NORM));
        check("alu_ctl_b", 32'(ctl_b), 32'(C_HAZ));
        step();
        check("alu_stall_a", 32'(stall_a), 32'd1);
        check("alu_stall_b", 32'(stall_b), 32'd2);

        // MEM-stage hit on src2 (three more hazard cycles on b -> saturates at 3).
        clr_in();
        id_valid = 1'b1; mem_wb_en = 1'b1; mem_dest = 4'd5;
        id_two_src = 1'b1; id_src2 = 4'd5;
        #1;
        check("memhit_ctl_a", 32'(ctl_a), 32'(C_NORM));
        check("memhit_ctl_b", 32'(ctl_b), 32'(C_HAZ));
        step();
        check("memhit_stall_b", 32'(stall_b), 32'd3);
        step();
        step();
        check("sat_stall_b", 32'(stall_b), 32'd3);
        check("memhit_stall_a", 32'(stall_a), 32'd1);
        id_two_src = 1'b0;
        #1;
        check("one_src_ctl_b", 32'(ctl_b), 32'(C_NORM));
        step();

        // Status-register hazard, then the same with no valid ID instruction.
        clr_in();
        id_valid = 1'b1; id_uses_sr = 1'b1; exe_s = 1'b1; id_src1 = 4'd1;
        #1;
        check("sr_ctl_a", 32'(ctl_a), 32'(C_HAZ));
        step();
        check("sr_stall_a", 32'(stall_a), 32'd2);
        id_valid = 1'b0;
        #1;
        check("sr_novalid_ctl_a", 32'(ctl_a), 32'(C_NORM));
        step();

        // Branch overrides a load-use hazard.
        clr_in();
        load_use();
        exe_b = 1'b1;
        #1;
        check("br_ctl_a", 32'(ctl_a), 32'(C_BR));
        check("br_ctl_b", 32'(ctl_b), 32'(C_BR));
        step();
        check("br_flush_a", 32'(flush_a), 32'd1);
        check("br_stall_a", 32'(stall_a), 32'd2);
        check("br_flush_b", 32'(flush_b), 32'd1);

        // Counter clear concurrent with a hazard.
        clr_in();
        load_use();
        perf_clr = 1'b1;
        #1;
        check("clr_ctl_b", 32'(ctl_b), 32'(C_HAZ));
        step();
        check("clr_stall_b", 32'(stall_b), 32'd0);
        check("clr_stall_a", 32'(stall_a), 32'd0);
        check("clr_flush_a", 32'(flush_a), 32'd0);
        perf_clr = 1'b0;
        step();
        check("after_clr_stall_b", 32'(stall_b), 32'd1);

        // Memory freeze with a branch held in EX; b times out after 3 FREEZE cycles.
        clr_in();
        exe_b = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        check("frz1_ctl_a", 32'(ctl_a), 32'(C_HOLD));
        check("frz1_ctl_b", 32'(ctl_b), 32'(C_HOLD));
        check("frz1_state_a", 32'(state_a), 32'd0);
        step();
        for (int i = 2; i <= 4; i++) begin
            #1;
            check($sformatf("frz%0d_state_a", i), 32'(state_a), 32'd1);
            check($sformatf("frz%0d_ctl_a", i), 32'(ctl_a), 32'(C_HOLD));
            step();
        end
        check("tmo_state_b", 32'(state_b), 32'd2);
        check("tmo_err_b", 32'(err_b), 32'd1);
        check("tmo_err_a", 32'(err_a), 32'd0);
        mem_ready = 1'b1;
        #1;
        check("frz5_state_a", 32'(state_a), 32'd1);
        check("frz5_ctl_a", 32'(ctl_a), 32'(C_HOLD));
        check("err_ctl_b", 32'(ctl_b), 32'(C_HOLD));
        step();
        mem_req = 1'b0;
        #1;
        check("unfrz_state_a", 32'(state_a), 32'd0);
        check("unfrz_ctl_a", 32'(ctl_a), 32'(C_BR));
        check("unfrz_freeze_a", 32'(freeze_a), 32'd5);
        check("unfrz_flush_a", 32'(flush_a), 32'd0);
        check("err_hold_state_b", 32'(state_b), 32'd2);
        check("err_hold_ctl_b", 32'(ctl_b), 32'(C_HOLD));
        check("sat_freeze_b", 32'(freeze_b), 32'd3);
        step();
        check("post_br_flush_a", 32'(flush_a), 32'd1);
        check("post_freeze_a", 32'(freeze_a), 32'd5);

        // Asynchronous reset mid-cycle clears the error state.
        #2;
        rst = 1'b0;
        #1;
        check("arst_state_b", 32'(state_b), 32'd0);
        check("arst_err_b", 32'(err_b), 32'd0);
        check("arst_freeze_b", 32'(freeze_b), 32'd0);
        check("arst_stall_b", 32'(stall_b), 32'd0);
        check("arst_ctl_b", 32'(ctl_b), 32'(C_HOLD));
        @(negedge clk);
        rst = 1'b1;
        clr_in();
        #1;
        check("rerun_ctl_b", 32'(ctl_b), 32'(C_NORM));
        step();
        check("rerun_state_b", 32'(state_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
